core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM that sequences the decode, execute and register-file datapath of the SwitchMCU core. It fetches one 32-bit instruction at a time over a request/acknowledge instruction-memory port and holds it stable for the datapath. It pulses the datapath enable for the decode and execute cycles, qualifies the register-file write in a dedicated writeback cycle, and computes the next PC from the execute-stage branch and jump flags. It sits between instruction memory and the decode/execute/regfile cluster, one level below the top-level core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset and on `start` from IDLE
- FETCH_TIMEOUT, 15, maximum cycles waiting for `imem_ack_i` before fault (4-bit counter)
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  begin execution from RESET_PC (sampled in IDLE only)
- imem_req_o  out  1  fetch request, held until acknowledged
- imem_addr_o  out  32  fetch address (= pc_o)
- imem_ack_i  in  1  fetch acknowledge; `imem_data_i` valid this cycle
- imem_data_i  in  32  fetched instruction word
- instruction_o  out  32  latched instruction driven to decode/execute
- pc_o  out  32  PC of the instruction in flight
- en_o  out  1  datapath enable (decode, execute)
- wb_en_o  out  1  register-file write qualifier (ANDed with execute's write flag at top level)
- branch_inst_i  in  1  execute: taken branch
- jump_inst_i  in  1  execute: jump
- target_i  in  32  execute: branch/jump target (alu_result_2)
- busy_o  out  1  high in any state except IDLE and HALT
- halted_o  out  1  high in HALT
- fault_o  out  1  sticky; fetch timeout or misaligned target

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: all strobes low. `start`=1 loads pc=RESET_PC, clears fault, goes to FETCH.
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - On imem_ack_i, latch instruction_o ← imem_data_i, drop req, go to DECODE.
  - Timeout counter increments each unacknowledged cycle. When it reaches FETCH_TIMEOUT with no ack, set fault_o and go to HALT.
- DECODE: en_o=1 for one cycle; go to EXECUTE.
  - If instruction is 32'h0010_0073 (EBREAK) or 32'h0000_0000, go to HALT instead. en_o is still 1 in that cycle.
- EXECUTE: en_o=1 for one cycle. Register next_pc:
  - target_i if branch_inst_i|jump_inst_i,
  - else pc+4 (mod 2^32, wraps silently).
  - A target with target_i[1:0]≠0 sets fault_o and goes to HALT; WRITEBACK is skipped.
- WRITEBACK: wb_en_o=1 for one cycle; pc←next_pc; go to FETCH.
- HALT: outputs idle. Only `reset` exits; `start` is ignored.
- instruction_o is stable from the DECODE cycle through the end of WRITEBACK.

## Timing
- Reset values:
  - state=IDLE, pc_o=RESET_PC, instruction_o=0
  - imem_req_o=0, en_o=0, wb_en_o=0
  - busy_o=0, halted_o=0, fault_o=0, timeout counter=0
- Reset has priority over every event, including an imem ack in the same cycle. Mid-operation reset aborts the instruction with no writeback.
- Per instruction: 1 + L fetch cycles (L = ack latency, ≥0 extra), then DECODE, EXECUTE, WRITEBACK. Minimum 4 cycles per instruction with a same-cycle ack.
- Ack is accepted in the same cycle req rises.
- imem_ack_i outside FETCH is ignored.
- branch_inst_i, jump_inst_i and target_i are sampled only in EXECUTE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SEQ_PERF_CNT_EN` defined:
  - Adds outputs cycle_cnt_o[31:0] and retired_cnt_o[31:0], both reset to 0.
  - cycle_cnt_o increments every cycle busy_o=1.
  - retired_cnt_o increments on each WRITEBACK cycle.
  - Both wrap at 2^32.
- Not defined: those ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, start, ack same cycle, instruction 0x00500093 -> 4-cycle loop; en_o high in cycles 2–3, wb_en_o high in cycle 4; next imem_addr_o = 0x4.
- Ack after 3-cycle delay -> imem_req_o held 4 cycles, instruction_o latched, pc_o unchanged.
- EXECUTE with jump_inst_i=1, target_i=0x100 -> next fetch at 0x100; branch_inst_i=0 -> pc+4. Start from pc 0xFFFF_FFFC -> next fetch at 0x0 (wrap).
- No ack for FETCH_TIMEOUT cycles -> fault_o=1, halted_o=1, busy_o=0. Then reset -> IDLE, fault_o=0.
- Fetch 0x00100073 -> HALT after DECODE with no wb_en_o pulse. target_i=0x102 on a jump -> fault_o=1, HALT.
- With `SEQ_PERF_CNT_EN`, three instructions with zero ack latency -> retired_cnt_o=3 and cycle_cnt_o=12 at the third WRITEBACK edge.

Source files
------------

// File: rtl/core_sequencer.sv
// Fetch/decode/execute/writeback control FSM for the SwitchMCU core.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        en_o,
  output logic        wb_en_o,
  input  logic        branch_inst_i,
  input  logic        jump_inst_i,
  input  logic [31:0] target_i,
  output logic        busy_o,
  output logic        halted_o,
  output logic        fault_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retired_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [3:0]  TO_LIMIT     = 4'(FETCH_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [3:0]  to_cnt_q, to_cnt_d;
  logic        req_q, req_d;
  logic        en_q, en_d;
  logic        wb_en_q, wb_en_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        redirect;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    to_cnt_d  = to_cnt_q;
    redirect  = branch_inst_i | jump_inst_i;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d     = RESET_PC;
          fault_d  = 1'b0;
          to_cnt_d = 4'd0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d  = imem_data_i;
          to_cnt_d = 4'd0;
          state_d  = S_DECODE;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
          if (to_cnt_d == TO_LIMIT) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_DECODE: begin
        if (instr_q == INSTR_EBREAK || instr_q == 32'h0000_0000) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        next_pc_d = redirect ? target_i : pc_q + 32'd4;
        // A misaligned redirect never reaches writeback.
        if (redirect && target_i[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        pc_d     = next_pc_q;
        to_cnt_d = 4'd0;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they register in step with it.
    req_d    = (state_d == S_FETCH);
    en_d     = (state_d == S_DECODE) || (state_d == S_EXECUTE);
    wb_en_d  = (state_d == S_WRITEBACK);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      fault_q   <= 1'b0;
      to_cnt_q  <= 4'd0;
      req_q     <= 1'b0;
      en_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      to_cnt_q  <= to_cnt_d;
      req_q     <= req_d;
      en_q      <= en_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instruction_o = instr_q;
  assign en_o          = en_q;
  assign wb_en_o       = wb_en_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + {31'd0, busy_q};
    retired_cnt_d = retired_cnt_q + {31'd0, wb_en_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer; inputs driven and outputs
// sampled on the falling clock edge.
module tb_core_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        en_o;
  logic        wb_en_o;
  logic        branch_inst_i;
  logic        jump_inst_i;
  logic [31:0] target_i;
  logic        busy_o;
  logic        halted_o;
  logic        fault_o;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_o;
  logic [31:0] retired_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  core_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .en_o          (en_o),
    .wb_en_o       (wb_en_o),
    .branch_inst_i (branch_inst_i),
    .jump_inst_i   (jump_inst_i),
    .target_i      (target_i),
    .busy_o        (busy_o),
    .halted_o      (halted_o),
    .fault_o       (fault_o)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt_o   (cycle_cnt_o),
    .retired_cnt_o (retired_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered in the first FETCH cycle; leaves in the following FETCH cycle.
  task automatic run_instr(input int lat, input logic [31:0] word, input logic [31:0] pc,
                           input logic br, input logic jmp, input logic [31:0] tgt);
    for (int i = 0; i < lat; i++) begin
      check_eq("fetch_req_wait", {31'd0, imem_req_o}, 32'd1);
      check_eq("fetch_addr_wait", imem_addr_o, pc);
      tick();
    end
    check_eq("fetch_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("fetch_addr", imem_addr_o, pc);
    imem_ack_i  = 1'b1;
    imem_data_i = word;
    tick();
    imem_ack_i  = 1'b0;
    imem_data_i = 32'hFFFF_FFFF;
    check_eq("dec_en", {31'd0, en_o}, 32'd1);
    check_eq("dec_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("dec_instr", instruction_o, word);
    check_eq("dec_pc", pc_o, pc);
    tick();
    check_eq("exe_en", {31'd0, en_o}, 32'd1);
    check_eq("exe_wb", {31'd0, wb_en_o}, 32'd0);
    branch_inst_i = br;
    jump_inst_i   = jmp;
    target_i      = tgt;
    tick();
    branch_inst_i = 1'b0;
    jump_inst_i   = 1'b0;
    target_i      = 32'h0;
    check_eq("wb_en", {31'd0, wb_en_o}, 32'd1);
    check_eq("wb_dp_en", {31'd0, en_o}, 32'd0);
    check_eq("wb_instr", instruction_o, word);
    check_eq("wb_pc", pc_o, pc);
    tick();
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
    branch_inst_i = 1'b0; jump_inst_i = 1'b0; target_i = 32'h0;
    tick(); tick();
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_instr", instruction_o, 32'h0);
    check_eq("rst_en", {31'd0, en_o}, 32'd0);
    check_eq("rst_wb", {31'd0, wb_en_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_halted", {31'd0, halted_o}, 32'd0);
    check_eq("rst_fault", {31'd0, fault_o}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_req", {31'd0, imem_req_o}, 32'd0);

    do_start();
    check_eq("start_busy", {31'd0, busy_o}, 32'd1);
    run_instr(0, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("seq_addr", imem_addr_o, 32'h4);

    // Delayed ack: previous instruction must stay on the bus while waiting.
    check_eq("lat_hold_instr", instruction_o, 32'h0050_0093);
    run_instr(3, 32'h00A0_0113, 32'h4, 1'b0, 1'b1, 32'h100);
    check_eq("jump_addr", imem_addr_o, 32'h100);

    run_instr(0, 32'h0000_0013, 32'h100, 1'b1, 1'b0, 32'hFFFF_FFFC);
    check_eq("branch_addr", imem_addr_o, 32'hFFFF_FFFC);
    run_instr(0, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0200);
    check_eq("wrap_addr", imem_addr_o, 32'h0);

    cnt = 0;
    while (imem_req_o && cnt < 40) begin
      cnt++;
      tick();
    end
    check_eq("timeout_cycles", cnt, 32'd15);
    check_eq("timeout_fault", {31'd0, fault_o}, 32'd1);
    check_eq("timeout_halted", {31'd0, halted_o}, 32'd1);
    check_eq("timeout_busy", {31'd0, busy_o}, 32'd0);
    do_start();
    tick();
    check_eq("halt_ignores_start", {31'd0, halted_o}, 32'd1);
    check_eq("halt_req", {31'd0, imem_req_o}, 32'd0);

    do_reset();
    check_eq("rerst_fault", {31'd0, fault_o}, 32'd0);
    check_eq("rerst_halted", {31'd0, halted_o}, 32'd0);
    check_eq("rerst_pc", pc_o, 32'h0);

    // EBREAK halts after DECODE with no writeback and no fault.
    do_start();
    imem_ack_i = 1'b1; imem_data_i = 32'h0010_0073;
    tick();
    imem_ack_i = 1'b0;
    check_eq("ebreak_dec_en", {31'd0, en_o}, 32'd1);
    tick();
    check_eq("ebreak_halted", {31'd0, halted_o}, 32'd1);
    check_eq("ebreak_wb", {31'd0, wb_en_o}, 32'd0);
    check_eq("ebreak_en", {31'd0, en_o}, 32'd0);
    check_eq("ebreak_fault", {31'd0, fault_o}, 32'd0);

    // Misaligned jump target.
    do_reset();
    do_start();
    imem_ack_i = 1'b1; imem_data_i = 32'h0000_0013;
    tick();
    imem_ack_i = 1'b0;
    tick();
    check_eq("mis_exe_en", {31'd0, en_o}, 32'd1);
    jump_inst_i = 1'b1; target_i = 32'h102;
    tick();
    jump_inst_i = 1'b0; target_i = 32'h0;
    check_eq("mis_fault", {31'd0, fault_o}, 32'd1);
    check_eq("mis_halted", {31'd0, halted_o}, 32'd1);
    check_eq("mis_wb", {31'd0, wb_en_o}, 32'd0);
    check_eq("mis_pc", pc_o, 32'h0);

    // Reset wins over a same-cycle ack.
    do_reset();
    do_start();
    imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF; reset = 1'b1;
    tick();
    imem_ack_i = 1'b0; reset = 1'b0;
    check_eq("rstack_instr", instruction_o, 32'h0);
    check_eq("rstack_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rstack_en", {31'd0, en_o}, 32'd0);
    tick();
    check_eq("rstack_idle_req", {31'd0, imem_req_o}, 32'd0);

`ifdef SEQ_PERF_CNT_EN
    do_reset();
    check_eq("perf_rst_cycle", cycle_cnt_o, 32'd0);
    check_eq("perf_rst_retired", retired_cnt_o, 32'd0);
    do_start();
    run_instr(0, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 32'h0);
    run_instr(0, 32'h0000_0013, 32'h4, 1'b0, 1'b0, 32'h0);
    run_instr(0, 32'h0000_0013, 32'h8, 1'b0, 1'b0, 32'h0);
    check_eq("perf_retired", retired_cnt_o, 32'd3);
    check_eq("perf_cycles", cycle_cnt_o, 32'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
